// File: rtl/vision_pkg.sv
// Shared defaults and sequencer state encoding for the vision row scheduler.
package vision_pkg;

  localparam int LINE_W_DEF = 320;
  localparam int ROWS_DEF   = 240;
  localparam int CNT_W_DEF  = 17;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    LOAD     = 3'd2,
    START    = 3'd3,
    WAIT_UPD = 3'd4,
    DRAIN    = 3'd5,
    CAPTURE  = 3'd6,
    ABORT    = 3'd7
  } sched_state_t;

  // States in which the core owns the line and the watchdog runs.
  function automatic logic is_waiting(sched_state_t s);
    return (s == WAIT_UPD) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/vision_watchdog.sv
// Saturating cycle counter with clear/enable; flags expiry on the cycle
// that makes the waited count reach TIMEOUT.
module vision_watchdog #(
  parameter int TIMEOUT = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, then count up while enabled, holding at TIMEOUT.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CW'(TIMEOUT))) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds cycles already spent; the current cycle is the (cnt_q+1)th.
  assign expired_o = en_i && (cnt_q >= CW'(TIMEOUT - 1));

endmodule

// File: rtl/vision_row_sched.sv
// Frame sequencer: streams each buffered line into vision_core, then
// publishes the core's final feature counts or flags a core timeout.
module vision_row_sched
  import vision_pkg::*;
#(
  parameter int LINE_W  = LINE_W_DEF,
  parameter int ROWS    = ROWS_DEF,
  parameter int ADDR_W  = 8,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [LINE_W-1:0] mem_rd_data,
  output logic [LINE_W-1:0] core_line_pixel,
  output logic              core_start,
  input  logic              core_data_update,
  input  logic              core_stop,
  input  logic [CNT_W-1:0]  core_cout_six,
  input  logic [CNT_W-1:0]  core_cout_o,
  input  logic [CNT_W-1:0]  core_cout_four,
  output logic              busy,
  output logic              res_valid,
  output logic [CNT_W-1:0]  res_six,
  output logic [CNT_W-1:0]  res_o,
  output logic [CNT_W-1:0]  res_four,
  output logic              err,
  output logic              frame_drop
);

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

  sched_state_t      state_q;
  logic [ADDR_W-1:0] row_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [LINE_W-1:0] line_q;
  logic [CNT_W-1:0]  six_q, o_q, four_q;
  logic              rd_en_q, start_q, valid_q, busy_q, err_q;
  logic              wd_expired;

  vision_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (state_q == START),
    .en_i      (is_waiting(state_q)),
    .expired_o (wd_expired)
  );

  // Sequencer FSM; every output is registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      row_q     <= '0;
      rd_addr_q <= '0;
      line_q    <= '0;
      six_q     <= '0;
      o_q       <= '0;
      four_q    <= '0;
      rd_en_q   <= 1'b0;
      start_q   <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (frame_start) begin
            row_q     <= '0;
            rd_addr_q <= '0;
            rd_en_q   <= 1'b1;
            err_q     <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= FETCH;
          end
        end
        FETCH: state_q <= LOAD;
        LOAD: begin
          line_q  <= mem_rd_data;
          start_q <= 1'b1;
          state_q <= START;
        end
        START: state_q <= WAIT_UPD;
        WAIT_UPD, DRAIN: begin
          // Counts are captured on the stop cycle so res_* and res_valid align.
          if (core_stop) begin
            six_q   <= core_cout_six;
            o_q     <= core_cout_o;
            four_q  <= core_cout_four;
            valid_q <= 1'b1;
            state_q <= CAPTURE;
          end else if ((state_q == WAIT_UPD) && core_data_update) begin
            if (row_q != LAST_ROW) begin
              row_q     <= row_q + ADDR_W'(1);
              rd_addr_q <= row_q + ADDR_W'(1);
              rd_en_q   <= 1'b1;
              state_q   <= FETCH;
            end else begin
              state_q <= DRAIN;
            end
          end else if (wd_expired) begin
            err_q   <= 1'b1;
            state_q <= ABORT;
          end
        end
        CAPTURE, ABORT: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_rd_en       = rd_en_q;
  assign mem_rd_addr     = rd_addr_q;
  assign core_line_pixel = line_q;
  assign core_start      = start_q;
  assign busy            = busy_q;
  assign res_valid       = valid_q;
  assign res_six         = six_q;
  assign res_o           = o_q;
  assign res_four        = four_q;
  assign err             = err_q;
  // A refused frame must be reported in the cycle it is offered.
  assign frame_drop      = frame_start & busy_q;

endmodule

// File: tb/tb_vision_row_sched.sv
// Self-checking bench for vision_row_sched: a table of frame scenarios driven
// through a behavioural line buffer and core model with random timing.
module tb_vision_row_sched;
  import vision_pkg::*;

  localparam int LINE_W  = LINE_W_DEF;
  localparam int ROWS    = ROWS_DEF;
  localparam int ADDR_W  = 8;
  localparam int CNT_W   = CNT_W_DEF;
  localparam int TIMEOUT = 100;
  localparam int M_NORMAL = 0, M_EARLY = 1, M_HANG = 2;

  typedef struct {
    int mode; int k; int delay; bit rnd_delay; bit rnd_cnt;
    int six; int o; int four; bit drop50; bit rst120;
    int exp_starts; int exp_valids; bit exp_err;
  } scen_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1, frame_start = 1'b0;
  logic              core_data_update = 1'b0, core_stop = 1'b0;
  logic [CNT_W-1:0]  core_cout_six = '0, core_cout_o = '0, core_cout_four = '0;
  logic              mem_rd_en, core_start, busy, res_valid, err, frame_drop;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [LINE_W-1:0] mem_rd_data = '0;
  logic [LINE_W-1:0] core_line_pixel;
  logic [CNT_W-1:0]  res_six, res_o, res_four;

  vision_row_sched #(.LINE_W(LINE_W), .ROWS(ROWS), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .core_line_pixel(core_line_pixel), .core_start(core_start),
    .core_data_update(core_data_update), .core_stop(core_stop),
    .core_cout_six(core_cout_six), .core_cout_o(core_cout_o), .core_cout_four(core_cout_four),
    .busy(busy), .res_valid(res_valid), .res_six(res_six), .res_o(res_o), .res_four(res_four),
    .err(err), .frame_drop(frame_drop)
  );

  logic [LINE_W-1:0] mem [ROWS];
  // Line buffer: data one cycle after the strobe, scrambled junk otherwise.
  always @(posedge clk) begin
    if (mem_rd_en && mem_rd_addr < ROWS) mem_rd_data <= mem[mem_rd_addr];
    else mem_rd_data <= ~mem_rd_data;
  end

  int n_checks = 0, n_errors = 0, cyc = 0;
  logic [CNT_W-1:0] last_six = '0, last_o = '0, last_four = '0;
  scen_t tbl[6];

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < ROWS; i++)
      for (int w = 0; w < LINE_W / 32; w++) mem[i][w*32 +: 32] = $urandom();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({mem_rd_en, core_start, res_valid, frame_drop} == 4'b0, {tag, "_strobes"},
        64'({mem_rd_en, core_start, res_valid, frame_drop}), 64'd0);
    chk(!busy && !err, {tag, "_busy_err"}, 64'({busy, err}), 64'd0);
    chk(mem_rd_addr == '0, {tag, "_addr"}, 64'(mem_rd_addr), 64'd0);
    chk(core_line_pixel == '0, {tag, "_pixel"}, core_line_pixel[63:0], 64'd0);
    chk({res_six, res_o, res_four} == '0, {tag, "_res"}, 64'({res_six, res_o, res_four}), 64'd0);
  endtask

  task automatic run_frame(input scen_t s);
    logic [CNT_W-1:0] six, o, four;
    int fs_cyc, upd_cyc, stop_cyc, start_cyc, err_cyc;
    int starts, fetches, valids, line_idx, cd, stop_cd;
    bit done, rst_live, drop_live;
    six  = s.rnd_cnt ? CNT_W'($urandom_range(0, 131071)) : CNT_W'(s.six);
    o    = s.rnd_cnt ? CNT_W'($urandom_range(0, 131071)) : CNT_W'(s.o);
    four = s.rnd_cnt ? CNT_W'($urandom_range(0, 131071)) : CNT_W'(s.four);
    fill_mem();
    core_cout_six = six; core_cout_o = o; core_cout_four = four;
    starts = 0; fetches = 0; valids = 0; line_idx = -1; cd = 0; stop_cd = 0;
    upd_cyc = -100; stop_cyc = -100; start_cyc = -100; err_cyc = -1;
    done = 1'b0; rst_live = 1'b0; drop_live = 1'b0;

    @(negedge clk); cyc++;
    frame_start = 1'b1; fs_cyc = cyc;
    #1 chk(frame_drop == 1'b0, "drop_idle", 64'(frame_drop), 64'd0);
    while (!done) begin
      @(negedge clk); cyc++;
      if (rst_live) begin
        check_reset_vals("midrst");
        rst = 1'b0;
        last_six = '0; last_o = '0; last_four = '0;
        done = 1'b1;
      end else begin
        if (cyc == fs_cyc + 1) begin
          chk(err == 1'b0, "err_clr", 64'(err), 64'd0);
          chk(mem_rd_en && mem_rd_addr == '0, "lat_fetch", 64'({mem_rd_en, mem_rd_addr}), 64'h100);
        end
        if (mem_rd_en) begin
          chk(mem_rd_addr == ADDR_W'(fetches), "addr", 64'(mem_rd_addr), 64'(fetches));
          fetches++;
        end
        if (core_start) begin
          if (starts == 0) chk(cyc == fs_cyc + 3, "lat_start0", 64'(cyc - fs_cyc), 64'd3);
          else chk(cyc == upd_cyc + 3, "lat_start", 64'(cyc - upd_cyc), 64'd3);
          if (starts < ROWS)
            chk(core_line_pixel == mem[starts], "line", core_line_pixel[63:0], mem[starts][63:0]);
          line_idx = starts; starts++; start_cyc = cyc;
          cd = (s.rnd_delay ? $urandom_range(1, 12) : s.delay) + 1;
        end
        if (res_valid) begin
          valids++;
          chk(cyc == stop_cyc + 1, "lat_valid", 64'(cyc - stop_cyc), 64'd1);
          chk({res_six, res_o, res_four} == {six, o, four}, "res",
              64'({res_six, res_o, res_four}), 64'({six, o, four}));
        end
        if (err && err_cyc < 0) err_cyc = cyc;
        if (!busy && cyc > fs_cyc + 1) begin
          done = 1'b1;
          if (s.exp_err) begin
            chk(err_cyc == start_cyc + TIMEOUT + 1, "abort_lat", 64'(err_cyc - start_cyc), 64'(TIMEOUT + 1));
            chk(cyc == start_cyc + TIMEOUT + 2, "abort_idle", 64'(cyc - start_cyc), 64'(TIMEOUT + 2));
          end else begin
            chk(cyc == stop_cyc + 2, "busy_fall", 64'(cyc - stop_cyc), 64'd2);
          end
        end else begin
          frame_start = 1'b0; core_data_update = 1'b0; core_stop = 1'b0;
          if (stop_cd > 0) begin
            stop_cd--;
            if (stop_cd == 0) begin core_stop = 1'b1; stop_cyc = cyc; end
          end
          if (cd > 0) begin
            cd--;
            if (cd == 0) begin
              if (s.mode == M_HANG && line_idx == s.k) begin
                cd = 0;
              end else if (s.mode == M_EARLY && line_idx == s.k) begin
                core_data_update = 1'b1; core_stop = 1'b1; upd_cyc = cyc; stop_cyc = cyc;
              end else begin
                core_data_update = 1'b1; upd_cyc = cyc;
                if (line_idx == ROWS - 1) stop_cd = 5;
              end
            end
          end
          if (s.drop50 && core_start && line_idx == 50) begin frame_start = 1'b1; drop_live = 1'b1; end
          if (s.rst120 && core_start && line_idx == 120) begin rst = 1'b1; rst_live = 1'b1; end
          if (cyc - fs_cyc > 20000) begin
            chk(1'b0, "frame_timeout", 64'(cyc - fs_cyc), 64'd20000);
            done = 1'b1;
          end
          #1;
          if (drop_live) begin
            chk(frame_drop == 1'b1, "frame_drop", 64'(frame_drop), 64'd1);
            drop_live = 1'b0;
          end
        end
      end
    end
    frame_start = 1'b0; core_data_update = 1'b0; core_stop = 1'b0;
    if (s.exp_valids == 1) begin last_six = six; last_o = o; last_four = four; end
    chk(starts == s.exp_starts, "n_starts", 64'(starts), 64'(s.exp_starts));
    chk(fetches == s.exp_starts, "n_fetches", 64'(fetches), 64'(s.exp_starts));
    chk(valids == s.exp_valids, "n_valids", 64'(valids), 64'(s.exp_valids));
    chk(err == s.exp_err, "err_end", 64'(err), 64'(s.exp_err));
    chk({res_six, res_o, res_four} == {last_six, last_o, last_four}, "res_hold",
        64'({res_six, res_o, res_four}), 64'({last_six, last_o, last_four}));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    tbl[0] = '{M_NORMAL, 0,  10, 1'b0, 1'b0, 3, 7, 2, 1'b0, 1'b0, 240, 1, 1'b0};
    tbl[1] = '{M_EARLY,  99, 0,  1'b1, 1'b1, 0, 0, 0, 1'b0, 1'b0, 100, 1, 1'b0};
    tbl[2] = '{M_HANG,   5,  4,  1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0, 6,   0, 1'b1};
    tbl[3] = '{M_NORMAL, 0,  0,  1'b1, 1'b1, 0, 0, 0, 1'b1, 1'b0, 240, 1, 1'b0};
    tbl[4] = '{M_NORMAL, 0,  0,  1'b1, 1'b1, 0, 0, 0, 1'b0, 1'b1, 121, 0, 1'b0};
    tbl[5] = '{M_NORMAL, 0,  0,  1'b1, 1'b1, 0, 0, 0, 1'b0, 1'b0, 240, 1, 1'b0};

    repeat (3) begin @(negedge clk); cyc++; end
    check_reset_vals("por");
    rst = 1'b0;

    // Core handshakes while idle must not start anything.
    core_data_update = 1'b1; core_stop = 1'b1;
    repeat (3) begin @(negedge clk); cyc++; end
    chk(!busy && !mem_rd_en && !core_start && !res_valid, "idle_quiet",
        64'({busy, mem_rd_en, core_start, res_valid}), 64'd0);
    core_data_update = 1'b0; core_stop = 1'b0;
    @(negedge clk); cyc++;

    for (int i = 0; i < 6; i++) run_frame(tbl[i]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
